// File: rtl/mac_pkg.sv
// Shared types and sizing for the Q-bit MAC datapath and its sequencing controller.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    localparam int Q_DEF     = 3;
    localparam int LEN_W_DEF = 4;

    // Product width plus headroom for up to 2^LEN_W-1 summed products.
    function automatic int acc_w(input int q, input int len_w);
        return 2 * q + len_w;
    endfunction

    localparam int ACC_W_DEF = acc_w(Q_DEF, LEN_W_DEF);

endpackage

// File: rtl/mac_beat_counter.sv
// Loadable down-counter of operand pairs still to be accepted; 1-cycle update, never wraps.
// o_last flags the final pair so the controller can leave RUN on that handshake.
module mac_beat_counter
    import mac_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W-1:0] o_rem,
    output logic             o_last
);

    logic [LEN_W-1:0] r_rem;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_len;
        end else if (i_dec && (r_rem != '0)) begin
            r_rem <= r_rem - 1'b1;
        end
    end

    assign o_rem  = r_rem;
    assign o_last = (r_rem == LEN_W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Meters len operand pairs into the MAC datapath; result valid len+1 cycles after start (+1 per stall).
// Upstream stalls via in_valid; the result is held in DONE until res_ready; i_rst is async active-low.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [Q-1:0]     i_a,
    input  logic [Q-1:0]     i_b,
    output logic [Q-1:0]     o_op_a,
    output logic [Q-1:0]     o_op_b,
    output logic             o_op_load,
    output logic             o_acc_clr,
    output logic             o_acc_en,
    output logic             o_res_valid,
    input  logic             i_res_ready
);

    mac_state_t       r_state;
    mac_state_t       w_state_nxt;
    logic             r_acc_clr;
    logic             r_acc_en;
    logic             w_cmd;
    logic             w_load;
    logic             w_hs;
    logic [LEN_W-1:0] w_rem;
    logic             w_last;

    assign w_cmd  = (r_state == ST_IDLE) && i_start;
    assign w_load = w_cmd && (i_len != '0);
    assign w_hs   = i_in_valid && o_in_ready;

    mac_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_dec  (w_hs),
        .i_len  (i_len),
        .o_rem  (w_rem),
        .o_last (w_last)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_hs && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (o_res_valid && i_res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // acc_en trails op_load by the operand-register stage; reset drops any in-flight enable.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc_clr <= 1'b0;
            r_acc_en  <= 1'b0;
        end else begin
            r_acc_clr <= w_cmd;
            r_acc_en  <= w_hs;
        end
    end

    // A zero-length command enters DONE while its clear is still pending, so the
    // result is only flagged once the accumulator actually reads zero.
    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_in_ready  = (r_state == ST_RUN);
        o_res_valid = (r_state == ST_DONE) && !r_acc_clr;
        o_acc_clr   = r_acc_clr;
        o_acc_en    = r_acc_en;
    end

    assign o_op_load = w_hs;
    assign o_op_a    = i_a;
    assign o_op_b    = i_b;

    a_clr_en_excl: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(r_acc_clr && r_acc_en));

    a_rem_nonzero_in_run: assert property (@(posedge i_clk) disable iff (!i_rst)
        (r_state == ST_RUN) |-> (w_rem != '0));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: stimulus pushes hand-computed expectations, a monitor
// checks each taken result against them using a behavioural operand-reg/multiplier/accumulator.
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_len = '0;
    logic       o_busy;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [2:0] i_a = '0;
    logic [2:0] i_b = '0;
    logic [2:0] o_op_a;
    logic [2:0] o_op_b;
    logic       o_op_load;
    logic       o_acc_clr;
    logic       o_acc_en;
    logic       o_res_valid;
    logic       i_res_ready = 1'b1;

    mac_seq_ctrl #(.Q(3), .LEN_W(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_op_a      (o_op_a),
        .o_op_b      (o_op_b),
        .o_op_load   (o_op_load),
        .o_acc_clr   (o_acc_clr),
        .o_acc_en    (o_acc_en),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int s;
        int lat;
        int res;
        int loads;
        int ens;
        int first;
    } exp_t;

    exp_t sb[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural datapath: operand registers, multiplier, accumulator.
    int       acc;
    logic [2:0] ra, rb;
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc <= 0; ra <= '0; rb <= '0;
        end else begin
            if (o_acc_clr)     acc <= 0;
            else if (o_acc_en) acc <= acc + int'(ra) * int'(rb);
            if (o_op_load) begin
                ra <= o_op_a;
                rb <= o_op_b;
            end
        end
    end

    // Monitor / scoreboard
    int n_load, n_en, first_en, rise, clr_cyc;
    bit prev_rv, pend_idle;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            n_load = 0; n_en = 0; first_en = -1; rise = -1; clr_cyc = -1;
            prev_rv = 1'b0; pend_idle = 1'b0;
        end else begin
            if (pend_idle) begin
                chk("idle_after_take_busy", int'(o_busy), 0);
                chk("idle_after_take_rv", int'(o_res_valid), 0);
                pend_idle = 1'b0;
            end
            if (o_acc_clr) clr_cyc = cyc;
            if (o_op_load) n_load++;
            if (o_acc_en) begin
                if (first_en < 0) first_en = cyc;
                n_en++;
            end
            if (o_res_valid && !prev_rv) rise = cyc;
            if (o_res_valid && i_res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("acc_clr_cycle", clr_cyc - e.s, 0);
                    chk("res_latency", rise - e.s, e.lat);
                    chk("result", acc, e.res);
                    chk("op_load_count", n_load, e.loads);
                    chk("acc_en_count", n_en, e.ens);
                    chk("first_acc_en", (first_en < 0) ? -1 : first_en - e.s, e.first);
                end
                n_load = 0; n_en = 0; first_en = -1;
                pend_idle = 1'b1;
            end
            prev_rv = o_res_valid;
        end
    end

    task automatic start_cmd(input int len, output int s);
        i_start = 1'b1;
        i_len   = 4'(len);
        @(posedge i_clk); #1;
        s       = cyc;
        i_start = 1'b0;
        i_len   = '0;
    endtask

    task automatic feed(input int a, input int b, input int gap);
        bit taken = 1'b0;
        int n = 0;
        i_in_valid = 1'b1;
        i_a = 3'(a);
        i_b = 3'(b);
        while (!taken && n < 64) begin
            @(negedge i_clk);
            taken = o_in_ready;
            @(posedge i_clk); #1;
            n++;
        end
        if (!taken) chk("feed_timeout", 0, 1);
        i_in_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 200) begin
            @(negedge i_clk);
            done = !o_busy && (sb.size() == 0);
            n++;
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge i_clk); #1;
    endtask

    task automatic wait_rv();
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 64) begin
            @(negedge i_clk);
            done = o_res_valid;
            n++;
        end
        if (!done) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      int'(o_busy), 0);
        chk({tag, "_in_ready"},  int'(o_in_ready), 0);
        chk({tag, "_op_load"},   int'(o_op_load), 0);
        chk({tag, "_acc_clr"},   int'(o_acc_clr), 0);
        chk({tag, "_acc_en"},    int'(o_acc_en), 0);
        chk({tag, "_res_valid"}, int'(o_res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // Reset state, with a valid pair presented that must not be loaded.
        i_in_valid = 1'b1; i_a = 3'd6; i_b = 3'd2;
        #3;
        chk_all_zero("reset");
        chk("reset_op_a", int'(o_op_a), 6);
        chk("reset_op_b", int'(o_op_b), 2);
        i_in_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;

        // Reset mid-RUN after two handshakes, with an enable in flight.
        start_cmd(5, s);
        feed(1, 1, 0);
        feed(2, 2, 0);
        i_in_valid = 1'b1; i_a = 3'd5; i_b = 3'd4;
        chk("pre_reset_acc_en", int'(o_acc_en), 1);
        i_rst = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        chk("midrun_reset_op_a", int'(o_op_a), 5);
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        start_cmd(1, s);
        sb.push_back('{s, 2, 15, 1, 1, 1});
        feed(5, 3, 0);
        wait_idle();

        // Continuous stream, len=3: 2*1 + 1*6 + 3*7 = 29.
        start_cmd(3, s);
        sb.push_back('{s, 4, 29, 3, 3, 1});
        feed(2, 1, 0);
        feed(1, 6, 0);
        feed(3, 7, 0);
        wait_idle();

        // Alternating stalls, len=4: 2 + 12 + 30 + 49 = 93, result in s+8.
        start_cmd(4, s);
        sb.push_back('{s, 8, 93, 4, 4, 1});
        feed(1, 2, 1);
        feed(3, 4, 1);
        feed(5, 6, 1);
        feed(7, 7, 0);
        wait_idle();

        // Zero length: clear only, result 0 in s+1.
        start_cmd(0, s);
        sb.push_back('{s, 1, 0, 0, 0, -1});
        wait_idle();

        // Backpressure plus ignored starts in RUN and DONE: 4*4 + 2*3 = 22.
        i_res_ready = 1'b0;
        start_cmd(2, s);
        sb.push_back('{s, 3, 22, 2, 2, 1});
        feed(4, 4, 0);
        i_start = 1'b1; i_len = 4'd7;
        feed(2, 3, 0);
        i_start = 1'b0; i_len = '0;
        wait_rv();
        @(posedge i_clk); #1;
        for (int k = 0; k < 5; k++) begin
            i_start = (k % 2 == 0);
            i_len   = 4'd9;
            @(negedge i_clk);
            chk("hold_res_valid", int'(o_res_valid), 1);
            chk("hold_busy", int'(o_busy), 1);
            chk("hold_in_ready", int'(o_in_ready), 0);
            @(posedge i_clk); #1;
        end
        i_start = 1'b0; i_len = '0;
        i_res_ready = 1'b1;
        wait_idle();

        // Maximum length, len=15 of (7,7): 15*49 = 735, result in s+16.
        start_cmd(15, s);
        sb.push_back('{s, 16, 735, 15, 15, 1});
        for (int k = 0; k < 15; k++) feed(7, 7, 0);
        wait_idle();

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the Q-bit MAC datapath: operand registers, then multiplier, then the accumulator register. It accepts a vector-length command and meters exactly `len` operand pairs into the datapath over a valid/ready handshake. It drives the operand-register load, the accumulator clear and the accumulator enable, tracking the one-cycle operand-register stage. It then holds a result-valid flag until the consumer takes the result.

## Interface
- `Q`, default 3: operand width of the controlled datapath; used only for the pass-through operand buses.
- `LEN_W`, default 4: width of the length command; the maximum vector length is 2^LEN_W−1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: command strobe; sampled only in IDLE.
- `len`  in  LEN_W: number of operand pairs; sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `in_valid`  in  1: upstream operand pair `a`, `b` is valid.
- `in_ready`  out  1: controller accepts a pair this cycle.
- `a`, `b`  in  Q: upstream operands.
- `op_a`, `op_b`  out  Q: operands forwarded to the operand registers (combinational pass-through).
- `op_load`  out  1: enables the operand registers; equals `in_valid & in_ready`.
- `acc_clr`  out  1: one-cycle accumulator clear.
- `acc_en`  out  1: accumulator enable; `op_load` delayed one cycle.
- `res_valid`  out  1: the accumulator holds the final result.
- `res_ready`  in  1: consumer accepts the result.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - `start`=1 and `len`≠0: load the down-counter `rem`←`len`, register `acc_clr`=1 for the next cycle, go to RUN.
  - `start`=1 and `len`=0: register `acc_clr`=1, go to DONE; the result is 0.
  - `start`=0: stay in IDLE.
- RUN
  - `in_ready`=1 throughout.
  - Each handshake decrements `rem`.
  - A handshake with `rem`=1 goes to DRAIN.
  - `in_valid`=0 stalls; no state change and no count change.
- DRAIN: `in_ready`=0; exactly one cycle, during which `acc_en` is high for the last pair. Then go to DONE.
- DONE
  - `res_valid`=1; hold it while `res_ready`=0.
  - `res_valid & res_ready` returns to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor an error.
- `acc_clr` and the first `op_load` may coincide; this is legal because the accumulator updates only on `acc_en`, one cycle later.
- `acc_clr` has priority over `acc_en` at the datapath. By construction the controller never asserts both together.
- `rem` never wraps: it decrements only in RUN on a handshake, and RUN is left at `rem`=1.
- Reset, including mid-RUN or mid-DONE
  - Forces IDLE and `rem`=0.
  - Clears the `acc_en` pipe flag, so an in-flight enable is dropped.
  - All outputs become 0: `busy`, `in_ready`, `op_load`, `acc_clr`, `acc_en`, `res_valid`.
  - `op_a`/`op_b` follow `a`/`b`.

## Timing
- Cycle k is the interval after rising edge k.
- Command: `start` is sampled at edge s. `busy` and `acc_clr` are high in cycle s, and `in_ready` is high from cycle s.
- Continuous `in_valid`, `len`=N:
  - Handshakes occur in cycles s … s+N−1.
  - `acc_en` is high in cycles s+1 … s+N; the last of these is the DRAIN cycle.
  - `res_valid` rises in cycle s+N+1.
- Stalls: each `in_valid`=0 cycle in RUN adds exactly one cycle to that latency.
- `len`=0: `res_valid` is high in cycle s+1, with `acc_clr` high in cycle s.
- Result: `res_valid` falls in the cycle after the `res_valid & res_ready` edge. The earliest next `start` is sampled at that same edge plus one.
- All outputs except `op_load`, `op_a` and `op_b` are registered or decoded from state only.

## Structure
- Shared package `mac_pkg`:
  - state enum `mac_state_t` (IDLE, RUN, DRAIN, DONE);
  - the `Q` and `LEN_W` defaults;
  - the `ACC_W` rule, 2·Q+LEN_W, for the datapath accumulator sizing.
- One sub-module, `mac_beat_counter`: LEN_W-bit loadable down-counter with inputs `load`, `dec` and `len`, and outputs `rem` and `last` (`last` = `rem`==1).

## Test plan
- Reset mid-RUN: `len`=5; assert `rst`=0 after 2 handshakes. Required: all outputs 0 immediately. After release, `start` with `len`=1 completes normally; `res_valid` appears 2 cycles after `start` is sampled.
- Continuous stream: `len`=3, `in_valid` held high. Required:
  - exactly 3 `op_load` pulses;
  - `acc_en` pulses in cycles s+1 … s+3;
  - `res_valid` in cycle s+4.
  - With a behavioural datapath, pairs (2,1), (1,6), (3,7) give a result of 29.
- Stalls: `len`=4 with `in_valid` toggling 1,0,1,0,… Required: 4 handshakes; `res_valid` rises in cycle s+8; `rem` never underflows.
- Zero length: `start` with `len`=0. Required: `acc_clr` in cycle s; no `op_load` or `acc_en`; `res_valid` in cycle s+1.
- Backpressure and ignored start: hold `res_ready`=0 for 5 cycles and pulse `start` during RUN and DONE. Required: `res_valid` stays high and the state is unchanged. Then `res_ready`=1 gives IDLE next cycle.
- Maximum length: `len`=15, `in_valid` held high. Required: 15 handshakes and `res_valid` in cycle s+16.
